// File: rtl/cache_pkg.sv
// Shared types and default parameters for the N-way cache controller.
package cache_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CHECK     = 3'd1,
        ST_WRITEBACK = 3'd2,
        ST_WB_WAIT   = 3'd3,
        ST_FILL_REQ  = 3'd4,
        ST_FILL_WAIT = 3'd5,
        ST_INSTALL   = 3'd6,
        ST_ERROR     = 3'd7
    } state_e;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } op_e;

    localparam int unsigned DEF_WAYS      = 32'd2;
    localparam int unsigned DEF_BURST_LEN = 32'd8;
    localparam int unsigned DEF_TIMEOUT   = 32'd1024;

    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 32'd2) ? 32'd1 : $clog2(n);
    endfunction

endpackage

// File: rtl/cache_perf_cnt.sv
// Saturating hit/miss/writeback event counters for the cache controller.
module cache_perf_cnt (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc_hit_i,
    input  logic        inc_miss_i,
    input  logic        inc_wb_i,
    output logic [31:0] hit_cnt_o,
    output logic [31:0] miss_cnt_o,
    output logic [31:0] wb_cnt_o
);

    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
        return (en && (v != 32'hFFFF_FFFF)) ? (v + 32'd1) : v;
    endfunction

    // Counter registers, cleared by reset and held at all-ones once saturated.
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt_o  <= 32'd0;
            miss_cnt_o <= 32'd0;
            wb_cnt_o   <= 32'd0;
        end else begin
            hit_cnt_o  <= sat_inc(hit_cnt_o, inc_hit_i);
            miss_cnt_o <= sat_inc(miss_cnt_o, inc_miss_i);
            wb_cnt_o   <= sat_inc(wb_cnt_o, inc_wb_i);
        end
    end

endmodule

// File: rtl/cache_ctrl_nway.sv
// N-way cache controller FSM: hit check, dirty-victim writeback, burst refill, write-miss install.
// Optional performance counters are enabled by defining CACHE_CTRL_PERF_CNT_EN.
module cache_ctrl_nway
    import cache_pkg::*;
#(
    parameter int unsigned WAYS      = DEF_WAYS,
    parameter int unsigned BURST_LEN = DEF_BURST_LEN,
    parameter int unsigned TIMEOUT   = DEF_TIMEOUT,
    localparam int unsigned WAY_W    = $clog2(WAYS),
    localparam int unsigned BEAT_W   = clog2_min1(BURST_LEN),
    localparam int unsigned WD_W     = clog2_min1(TIMEOUT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_read_i,
    input  logic              cpu_write_i,
    input  logic              hit_i,
    input  logic [WAY_W-1:0]  hit_way_i,
    input  logic [WAY_W-1:0]  lru_way_i,
    input  logic [WAYS-1:0]   is_valid_i,
    input  logic [WAYS-1:0]   is_dirty_i,
    input  logic              mem_ack_i,
    input  logic              mem_rvalid_i,
    output logic              cpu_ready_o,
    output logic              mem_read_o,
    output logic              mem_write_o,
    output logic [WAYS-1:0]   load_data_o,
    output logic [WAYS-1:0]   load_tag_o,
    output logic [BEAT_W-1:0] beat_idx_o,
    output logic              data_in_select_o,
    output logic              lru_load_o,
    output logic [WAY_W-1:0]  lru_touch_o,
    output logic [WAYS-1:0]   set_valid_o,
    output logic [WAYS-1:0]   write_valid_o,
    output logic [WAYS-1:0]   set_dirty_o,
    output logic [WAYS-1:0]   write_dirty_o,
`ifdef CACHE_CTRL_PERF_CNT_EN
    output logic [31:0]       hit_cnt_o,
    output logic [31:0]       miss_cnt_o,
    output logic [31:0]       wb_cnt_o,
`endif
    output logic              error_o
);

    state_e              state_q, state_d;
    op_e                 op_q, op_d;
    logic [WAY_W-1:0]    victim_q, victim_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic [WD_W-1:0]     wd_q, wd_d;
    logic                cpu_ready_q, cpu_ready_d, mem_read_q, mem_read_d, mem_write_q, mem_write_d;
    logic [WAYS-1:0]     load_data_q, load_data_d, load_tag_q, load_tag_d;
    logic [BEAT_W-1:0]   beat_idx_q, beat_idx_d;
    logic                dis_q, dis_d, lru_load_q, lru_load_d, error_q, error_d;
    logic [WAY_W-1:0]    lru_touch_q, lru_touch_d;
    logic [WAYS-1:0]     set_valid_q, set_valid_d, write_valid_q, write_valid_d;
    logic [WAYS-1:0]     set_dirty_q, set_dirty_d, write_dirty_q, write_dirty_d;
    logic [WAYS-1:0]     victim_oh_s, hit_oh_s;
    logic                clean_s, take_beat_s, wd_expired_s;

    assign victim_oh_s  = WAYS'(1) << victim_q;
    assign hit_oh_s     = WAYS'(1) << hit_way_i;
    assign wd_expired_s = (wd_q == WD_W'(TIMEOUT - 32'd1));

    // Next-state and registered-output decode; every strobe defaults low each cycle.
    always_comb begin
        state_d = state_q;     op_d = op_q;          victim_d = victim_q;
        beat_d = beat_q;       wd_d = wd_q;
        cpu_ready_d = 1'b0;    mem_read_d = 1'b0;    mem_write_d = 1'b0;
        load_data_d = '0;      load_tag_d = '0;      beat_idx_d = '0;
        dis_d = 1'b0;          lru_load_d = 1'b0;    lru_touch_d = '0;
        set_valid_d = '0;      write_valid_d = '0;   set_dirty_d = '0;
        write_dirty_d = '0;    error_d = 1'b0;
        clean_s = 1'b0;        take_beat_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                beat_d = '0;
                wd_d   = '0;
                if (cpu_read_i || cpu_write_i) begin
                    op_d     = cpu_write_i ? OP_WR : OP_RD;
                    victim_d = lru_way_i;
                    state_d  = ST_CHECK;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CHECK: begin
                if (!hit_i) begin
                    state_d = ST_WRITEBACK;
                end else if (is_valid_i[hit_way_i]) begin
                    lru_load_d  = 1'b1;
                    lru_touch_d = hit_way_i;
                    cpu_ready_d = 1'b1;
                    if (op_q == OP_WR) begin
                        set_dirty_d   = hit_oh_s;
                        write_dirty_d = hit_oh_s;
                    end else begin
                        set_dirty_d = '0;
                    end
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_ERROR;
                end
            end
            ST_WRITEBACK: begin
                if (is_valid_i[victim_q] && is_dirty_i[victim_q]) begin
                    mem_write_d = 1'b1;
                    wd_d        = '0;
                    state_d     = ST_WB_WAIT;
                end else begin
                    clean_s = 1'b1;
                end
            end
            ST_WB_WAIT: begin
                if (mem_ack_i) begin
                    clean_s = 1'b1;
                end else if (wd_expired_s) begin
                    state_d = ST_ERROR;
                end else begin
                    mem_write_d = 1'b1;
                    wd_d        = wd_q + WD_W'(1);
                end
            end
            ST_FILL_REQ: begin
                // A beat arriving alongside the ack is already part of the burst.
                if (mem_ack_i) begin
                    wd_d        = '0;
                    state_d     = ST_FILL_WAIT;
                    take_beat_s = mem_rvalid_i;
                end else if (wd_expired_s) begin
                    state_d = ST_ERROR;
                end else begin
                    mem_read_d = 1'b1;
                    wd_d       = wd_q + WD_W'(1);
                end
            end
            ST_FILL_WAIT: begin
                if (mem_rvalid_i) begin
                    take_beat_s = 1'b1;
                end else if (wd_expired_s) begin
                    state_d = ST_ERROR;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
            end
            ST_INSTALL: begin
                load_data_d   = victim_oh_s;
                load_tag_d    = victim_oh_s;
                set_valid_d   = victim_oh_s;
                write_valid_d = victim_oh_s;
                set_dirty_d   = victim_oh_s;
                write_dirty_d = victim_oh_s;
                state_d       = ST_CHECK;
            end
            ST_ERROR: begin
                error_d = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (clean_s) begin
            wd_d = '0;
            if (op_q == OP_WR) begin
                state_d = ST_INSTALL;
            end else begin
                mem_read_d = 1'b1;
                beat_d     = '0;
                state_d    = ST_FILL_REQ;
            end
        end else begin
            clean_s = 1'b0;
        end

        if (take_beat_s) begin
            load_data_d = victim_oh_s;
            dis_d       = 1'b1;
            beat_idx_d  = beat_q;
            wd_d        = '0;
            if (beat_q == BEAT_W'(BURST_LEN - 32'd1)) begin
                load_tag_d    = victim_oh_s;
                set_valid_d   = victim_oh_s;
                write_valid_d = victim_oh_s;
                write_dirty_d = victim_oh_s;
                beat_d        = '0;
                state_d       = ST_CHECK;
            end else begin
                beat_d = beat_q + BEAT_W'(1);
            end
        end else begin
            take_beat_s = 1'b0;
        end
    end

    // State, bookkeeping and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;  op_q <= OP_RD;  victim_q <= '0;  beat_q <= '0;  wd_q <= '0;
            cpu_ready_q <= 1'b0;  mem_read_q <= 1'b0;  mem_write_q <= 1'b0;
            load_data_q <= '0;  load_tag_q <= '0;  beat_idx_q <= '0;  dis_q <= 1'b0;
            lru_load_q <= 1'b0;  lru_touch_q <= '0;  set_valid_q <= '0;  write_valid_q <= '0;
            set_dirty_q <= '0;  write_dirty_q <= '0;  error_q <= 1'b0;
        end else begin
            state_q <= state_d;  op_q <= op_d;  victim_q <= victim_d;  beat_q <= beat_d;  wd_q <= wd_d;
            cpu_ready_q <= cpu_ready_d;  mem_read_q <= mem_read_d;  mem_write_q <= mem_write_d;
            load_data_q <= load_data_d;  load_tag_q <= load_tag_d;  beat_idx_q <= beat_idx_d;  dis_q <= dis_d;
            lru_load_q <= lru_load_d;  lru_touch_q <= lru_touch_d;  set_valid_q <= set_valid_d;
            write_valid_q <= write_valid_d;  set_dirty_q <= set_dirty_d;  write_dirty_q <= write_dirty_d;
            error_q <= error_d;
        end
    end

    assign cpu_ready_o      = cpu_ready_q;
    assign mem_read_o       = mem_read_q;
    assign mem_write_o      = mem_write_q;
    assign load_data_o      = load_data_q;
    assign load_tag_o       = load_tag_q;
    assign beat_idx_o       = beat_idx_q;
    assign data_in_select_o = dis_q;
    assign lru_load_o       = lru_load_q;
    assign lru_touch_o      = lru_touch_q;
    assign set_valid_o      = set_valid_q;
    assign write_valid_o    = write_valid_q;
    assign set_dirty_o      = set_dirty_q;
    assign write_dirty_o    = write_dirty_q;
    assign error_o          = error_q;

`ifdef CACHE_CTRL_PERF_CNT_EN
    logic inc_hit_s, inc_miss_s, inc_wb_s;

    assign inc_hit_s  = (state_q == ST_CHECK) && hit_i && is_valid_i[hit_way_i];
    assign inc_miss_s = (state_q == ST_CHECK) && !hit_i;
    assign inc_wb_s   = (state_q == ST_WRITEBACK) && is_valid_i[victim_q] && is_dirty_i[victim_q];

    cache_perf_cnt u_perf_cnt (
        .clk        (clk),
        .rst        (rst),
        .inc_hit_i  (inc_hit_s),
        .inc_miss_i (inc_miss_s),
        .inc_wb_i   (inc_wb_s),
        .hit_cnt_o  (hit_cnt_o),
        .miss_cnt_o (miss_cnt_o),
        .wb_cnt_o   (wb_cnt_o)
    );
`endif

endmodule
